// File: rtl/alu_exec_unit_if.sv
// Operation/result bundle between the ID/EX register, the execute-stage ALU and EX/MEM.
// The ALU connects through the slave modport.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, alu_op, funct, a, b,
    input  in_ready, out_valid, result, zero, illegal, hi, lo
  );

  modport slave (
    input  in_valid, alu_op, funct, a, b,
    output in_ready, out_valid, result, zero, illegal, hi, lo
  );
endinterface

// File: rtl/alu_exec_unit.sv
// MIPS32 execute-stage ALU: single-cycle decode/datapath plus an iterative
// unsigned MULTU/DIVU engine writing the HI/LO registers.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  alu_exec_unit_if.slave bus
);
  localparam int               CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZEROS    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10
  } state_t;

  typedef enum logic [3:0] {
    K_ADD   = 4'd0,
    K_SUB   = 4'd1,
    K_AND   = 4'd2,
    K_OR    = 4'd3,
    K_SLT   = 4'd4,
    K_MFHI  = 4'd5,
    K_MFLO  = 4'd6,
    K_MULTU = 4'd7,
    K_DIVU  = 4'd8,
    K_ILL   = 4'd9
  } kind_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_zero;
  logic               r_illegal;
  logic               r_out_valid;

  kind_t              w_kind;
  logic [WIDTH-1:0]   w_alu_res;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;

  // Decode ALUOp/funct into an operation kind
  always_comb begin
    w_kind = K_ILL;
    case (bus.alu_op)
      3'b000: w_kind = K_ADD;
      3'b001: w_kind = K_SUB;
      3'b010: begin
        case (bus.funct)
          6'b100000: w_kind = K_ADD;
          6'b100010: w_kind = K_SUB;
          6'b100100: w_kind = K_AND;
          6'b100101: w_kind = K_OR;
          6'b101010: w_kind = K_SLT;
          6'b010000: w_kind = K_MFHI;
          6'b010010: w_kind = K_MFLO;
          6'b011001: w_kind = K_MULTU;
          6'b011011: w_kind = K_DIVU;
          default:   w_kind = K_ILL;
        endcase
      end
      default: w_kind = K_ILL;
    endcase
  end

  // Single-cycle datapath result
  always_comb begin
    w_alu_res = ZEROS;
    case (w_kind)
      K_ADD:   w_alu_res = bus.a + bus.b;
      K_SUB:   w_alu_res = bus.a - bus.b;
      K_AND:   w_alu_res = bus.a & bus.b;
      K_OR:    w_alu_res = bus.a | bus.b;
      K_SLT:   w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      K_MFHI:  w_alu_res = r_hi;
      K_MFLO:  w_alu_res = r_lo;
      default: w_alu_res = ZEROS;
    endcase
  end

  // One shift-add multiply step and one restoring-divide step on the shared accumulator
  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
    w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    if (r_acc[0]) begin
      w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    end else begin
      w_mul_next = {1'b0, r_acc[2*WIDTH-1:1]};
    end
    // Divide: acc = {remainder, dividend/quotient}; the shifted remainder needs one extra bit
    w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_div_ge   = (w_rem_sh >= {1'b0, r_opnd});
    w_div_diff = w_rem_sh[WIDTH-1:0] - r_opnd;
    if (w_div_ge) begin
      w_div_next = {w_div_diff, r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_div_next = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
  end

  // FSM, result registers and HI/LO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= CNT_ZERO;
      r_acc       <= {ZEROS, ZEROS};
      r_opnd      <= ZEROS;
      r_result    <= ZEROS;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
      r_hi        <= ZEROS;
      r_lo        <= ZEROS;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            case (w_kind)
              K_MULTU: begin
                r_acc   <= {ZEROS, bus.b};
                r_opnd  <= bus.a;
                r_cnt   <= CNT_ZERO;
                r_state <= S_MUL;
              end
              K_DIVU: begin
                if (bus.b == ZEROS) begin
                  r_hi        <= bus.a;
                  r_lo        <= ONES;
                  r_result    <= ZEROS;
                  r_zero      <= 1'b1;
                  r_illegal   <= 1'b0;
                  r_out_valid <= 1'b1;
                end else begin
                  r_acc   <= {ZEROS, bus.a};
                  r_opnd  <= bus.b;
                  r_cnt   <= CNT_ZERO;
                  r_state <= S_DIV;
                end
              end
              default: begin
                r_result    <= w_alu_res;
                r_zero      <= (w_alu_res == ZEROS);
                r_illegal   <= (w_kind == K_ILL);
                r_out_valid <= 1'b1;
              end
            endcase
          end
        end
        S_MUL, S_DIV: begin
          r_acc <= (r_state == S_MUL) ? w_mul_next : w_div_next;
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            if (r_state == S_MUL) begin
              r_hi <= w_mul_next[2*WIDTH-1:WIDTH];
              r_lo <= w_mul_next[WIDTH-1:0];
            end else begin
              r_hi <= w_div_next[2*WIDTH-1:WIDTH];
              r_lo <= w_div_next[WIDTH-1:0];
            end
            r_cnt       <= CNT_ZERO;
            r_result    <= ZEROS;
            r_zero      <= 1'b1;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.illegal   = r_illegal;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
endmodule
